// File: rtl/d_hazard_ctrl_if.sv
// D-stage hazard controller port bundle: decoded D-stage fields in, stall/forward/flush
// controls and branch statistics out.
interface d_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2
);
  logic              d_valid;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic              d_wr;
  logic [REG_AW-1:0] d_wa;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_likely;
  logic              d_jump_b;
  logic              ext_stall;
  logic              stall;
  logic              pc_en;
  logic              fd_en;
  logic              de_clr;
  logic              fd_flush;
  logic [1:0]        fwd_rs_d;
  logic [1:0]        fwd_rt_d;
  logic [31:0]       br_stall_cnt;
  logic [31:0]       annul_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr, d_wa, d_tnew,
           d_likely, d_jump_b, ext_stall,
    input  stall, pc_en, fd_en, de_clr, fd_flush, fwd_rs_d, fwd_rt_d,
           br_stall_cnt, annul_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr, d_wa, d_tnew,
           d_likely, d_jump_b, ext_stall,
    output stall, pc_en, fd_en, de_clr, fd_flush, fwd_rs_d, fwd_rt_d,
           br_stall_cnt, annul_cnt
  );
endinterface

// File: rtl/d_hazard_ctrl.sv
// D-stage hazard/stall sequencer with an E/M/W shadow pipeline of {valid, dest, Tnew}.
// Optional branch statistics counters are enabled by defining BR_STAT_EN.
module d_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2
) (
  input logic            clk,
  input logic            reset_n,
  d_hazard_ctrl_if.slave bus
);

  localparam logic [TNEW_W-1:0] TN_ZERO = {TNEW_W{1'b0}};
  localparam logic [TNEW_W-1:0] TN_ONE  = {{(TNEW_W-1){1'b0}}, 1'b1};
  localparam logic [TNEW_W-1:0] TN_MAX  = {TNEW_W{1'b1}};
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  logic              e_v_q, e_v_d;
  logic [REG_AW-1:0] e_wa_q, e_wa_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic              m_v_q, m_v_d;
  logic [REG_AW-1:0] m_wa_q, m_wa_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic              w_v_q, w_v_d;
  logic [REG_AW-1:0] w_wa_q, w_wa_d;

  logic [2:0] rs_res_s;
  logic [2:0] rt_res_s;
  logic       hz_s;
  logic       stall_s;
  logic       flush_s;
  logic       br_hz_s;

  // Result is {hazard, fwd_sel}; the youngest matching slot alone decides.
  // W always holds a ready value, so it only ever forwards.
  function automatic logic [2:0] op_eval(
    input logic              valid,
    input logic [REG_AW-1:0] r,
    input logic [TNEW_W-1:0] tuse,
    input logic              ev,
    input logic [REG_AW-1:0] ewa,
    input logic [TNEW_W-1:0] et,
    input logic              mv,
    input logic [REG_AW-1:0] mwa,
    input logic [TNEW_W-1:0] mt,
    input logic              wv,
    input logic [REG_AW-1:0] wwa
  );
    logic [2:0]        res;
    logic [TNEW_W-1:0] tuse_m;
    res    = 3'b000;
    tuse_m = (tuse == TN_ZERO) ? TN_ZERO : (tuse - TN_ONE);
    if (!valid || r == REG_ZERO || tuse == TN_MAX) begin
      res = 3'b000;
    end else if (ev && ewa == r) begin
      if (et == TN_ZERO) res = 3'b001;
      else if (et > tuse) res = 3'b100;
      else res = 3'b000;
    end else if (mv && mwa == r) begin
      if (mt == TN_ZERO) res = 3'b010;
      else if (mt > tuse_m) res = 3'b100;
      else res = 3'b000;
    end else if (wv && wwa == r) begin
      res = 3'b011;
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // Per-cycle hazard decision, control outputs and shadow-pipeline next state.
  always_comb begin
    rs_res_s = op_eval(bus.d_valid, bus.d_rs, bus.d_tuse_rs, e_v_q, e_wa_q, e_tnew_q,
                       m_v_q, m_wa_q, m_tnew_q, w_v_q, w_wa_q);
    rt_res_s = op_eval(bus.d_valid, bus.d_rt, bus.d_tuse_rt, e_v_q, e_wa_q, e_tnew_q,
                       m_v_q, m_wa_q, m_tnew_q, w_v_q, w_wa_q);
    hz_s     = rs_res_s[2] | rt_res_s[2];
    stall_s  = hz_s | bus.ext_stall;
    flush_s  = bus.d_valid & bus.d_likely & ~bus.d_jump_b & ~stall_s;
    br_hz_s  = (rs_res_s[2] && bus.d_tuse_rs == TN_ZERO) ||
               (rt_res_s[2] && bus.d_tuse_rt == TN_ZERO);

    // A stalled D instruction must not enter E, hence the bubble.
    e_v_d    = bus.d_valid & bus.d_wr & ~stall_s;
    e_wa_d   = bus.d_wa;
    e_tnew_d = bus.d_tnew;
    m_v_d    = e_v_q;
    m_wa_d   = e_wa_q;
    if (e_tnew_q == TN_ZERO) begin
      m_tnew_d = TN_ZERO;
    end else begin
      m_tnew_d = e_tnew_q - TN_ONE;
    end
    w_v_d    = m_v_q;
    w_wa_d   = m_wa_q;
  end

  assign bus.stall    = stall_s;
  assign bus.pc_en    = ~stall_s;
  assign bus.fd_en    = ~stall_s;
  assign bus.de_clr   = stall_s;
  assign bus.fd_flush = flush_s;
  assign bus.fwd_rs_d = rs_res_s[1:0];
  assign bus.fwd_rt_d = rt_res_s[1:0];

  // Shadow pipeline slots advance every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_v_q    <= 1'b0;
      e_wa_q   <= REG_ZERO;
      e_tnew_q <= TN_ZERO;
      m_v_q    <= 1'b0;
      m_wa_q   <= REG_ZERO;
      m_tnew_q <= TN_ZERO;
      w_v_q    <= 1'b0;
      w_wa_q   <= REG_ZERO;
    end else begin
      e_v_q    <= e_v_d;
      e_wa_q   <= e_wa_d;
      e_tnew_q <= e_tnew_d;
      m_v_q    <= m_v_d;
      m_wa_q   <= m_wa_d;
      m_tnew_q <= m_tnew_d;
      w_v_q    <= w_v_d;
      w_wa_q   <= w_wa_d;
    end
  end

`ifdef BR_STAT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] annul_cnt_q, annul_cnt_d;

  // Statistics next state; both counters wrap naturally.
  always_comb begin
    if (br_hz_s) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end else begin
      br_cnt_d = br_cnt_q;
    end
    if (flush_s) begin
      annul_cnt_d = annul_cnt_q + 32'd1;
    end else begin
      annul_cnt_d = annul_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_cnt_q    <= 32'd0;
      annul_cnt_q <= 32'd0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      annul_cnt_q <= annul_cnt_d;
    end
  end

  assign bus.br_stall_cnt = br_cnt_q;
  assign bus.annul_cnt    = annul_cnt_q;
`else
  logic unused_br_s;
  assign unused_br_s      = br_hz_s;
  assign bus.br_stall_cnt = 32'h0;
  assign bus.annul_cnt    = 32'h0;
`endif

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// Directed-vector bench for d_hazard_ctrl; counter expectations follow BR_STAT_EN.
module tb_d_hazard_ctrl;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  d_hazard_ctrl_if #(.REG_AW(5), .TNEW_W(2)) hz_if ();

  d_hazard_ctrl #(.REG_AW(5), .TNEW_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef BR_STAT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic drive_d(input logic v, input logic [4:0] rs, input logic [1:0] urs,
                         input logic [4:0] rt, input logic [1:0] urt, input logic wr,
                         input logic [4:0] wa, input logic [1:0] tn, input logic lk,
                         input logic jb, input logic ext);
    hz_if.d_valid   = v;
    hz_if.d_rs      = rs;
    hz_if.d_tuse_rs = urs;
    hz_if.d_rt      = rt;
    hz_if.d_tuse_rt = urt;
    hz_if.d_wr      = wr;
    hz_if.d_wa      = wa;
    hz_if.d_tnew    = tn;
    hz_if.d_likely  = lk;
    hz_if.d_jump_b  = jb;
    hz_if.ext_stall = ext;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive_d(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) advance();
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    drive_d(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #2;
    check_val("rst_stall_ext", {31'd0, hz_if.stall}, 32'd1);
    check_val("rst_pc_en_ext", {31'd0, hz_if.pc_en}, 32'd0);
    hz_if.ext_stall = 1'b0;
    #1;
    check_val("rst_stall", {31'd0, hz_if.stall}, 32'd0);
    check_val("rst_fd_en", {31'd0, hz_if.fd_en}, 32'd1);
    check_val("rst_fwd", {28'd0, hz_if.fwd_rs_d, hz_if.fwd_rt_d}, 32'd0);
    check_val("rst_flush", {31'd0, hz_if.fd_flush}, 32'd0);
    check_val("rst_brcnt", hz_if.br_stall_cnt, 32'd0);
    check_val("rst_annul", hz_if.annul_cnt, 32'd0);
    settle();
    reset_n = 1'b1;
    advance();

    // lw $1 then beq $1,$2: two stall cycles, then forward from W
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    settle();
    check_val("lw_issue_stall", {31'd0, hz_if.stall}, 32'd0);
    advance();
    drive_d(1'b1, 5'd1, 2'd0, 5'd2, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check_val("lw_beq_stall1", {31'd0, hz_if.stall}, 32'd1);
    check_val("lw_beq_pc_en1", {31'd0, hz_if.pc_en}, 32'd0);
    check_val("lw_beq_de_clr1", {31'd0, hz_if.de_clr}, 32'd1);
    advance();
    settle();
    check_val("lw_beq_stall2", {31'd0, hz_if.stall}, 32'd1);
    advance();
    settle();
    check_val("lw_beq_stall3", {31'd0, hz_if.stall}, 32'd0);
    check_val("lw_beq_fwd_rs", {30'd0, hz_if.fwd_rs_d}, 32'd3);
    check_val("lw_beq_fwd_rt", {30'd0, hz_if.fwd_rt_d}, 32'd0);
    check_val("lw_beq_pc_en3", {31'd0, hz_if.pc_en}, 32'd1);
    advance();
    check_val("lw_beq_brcnt", hz_if.br_stall_cnt, cnt_exp(2));
    drain();

    // addu $3 then bltzal $3 (links $31): one stall, then forward from M
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    advance();
    drive_d(1'b1, 5'd3, 2'd0, 5'd0, 2'd0, 1'b1, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check_val("addu_bltzal_stall1", {31'd0, hz_if.stall}, 32'd1);
    advance();
    settle();
    check_val("addu_bltzal_stall2", {31'd0, hz_if.stall}, 32'd0);
    check_val("addu_bltzal_fwd_rs", {30'd0, hz_if.fwd_rs_d}, 32'd2);
    advance();

    // link $31 now in E with tnew 0; beq $31,$0 forwards from E without stall
    drive_d(1'b1, 5'd31, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check_val("link_beq_stall", {31'd0, hz_if.stall}, 32'd0);
    check_val("link_beq_fwd_rs", {30'd0, hz_if.fwd_rs_d}, 32'd1);
    check_val("link_beq_fwd_rt", {30'd0, hz_if.fwd_rt_d}, 32'd0);
    advance();
    check_val("link_beq_brcnt", hz_if.br_stall_cnt, cnt_exp(3));

    // bltzall $4 not taken: annul; taken: no annul; stalled: no annul
    drive_d(1'b1, 5'd4, 2'd0, 5'd0, 2'd0, 1'b1, 5'd31, 2'd0, 1'b1, 1'b0, 1'b0);
    settle();
    check_val("likely_nt_flush", {31'd0, hz_if.fd_flush}, 32'd1);
    advance();
    check_val("likely_annul1", hz_if.annul_cnt, cnt_exp(1));
    hz_if.d_jump_b = 1'b1;
    settle();
    check_val("likely_tk_flush", {31'd0, hz_if.fd_flush}, 32'd0);
    advance();
    hz_if.d_jump_b  = 1'b0;
    hz_if.ext_stall = 1'b1;
    settle();
    check_val("likely_stall_flush", {31'd0, hz_if.fd_flush}, 32'd0);
    check_val("likely_ext_stall", {31'd0, hz_if.stall}, 32'd1);
    advance();
    check_val("likely_annul2", hz_if.annul_cnt, cnt_exp(1));
    drain();

    // lw $5 then addu using $5 (tuse 1) with ext_stall coinciding
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    advance();
    drive_d(1'b1, 5'd5, 2'd1, 5'd0, 2'd1, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b1);
    settle();
    check_val("lw_alu_ext_stall1", {31'd0, hz_if.stall}, 32'd1);
    advance();
    hz_if.ext_stall = 1'b0;
    settle();
    check_val("lw_alu_stall2", {31'd0, hz_if.stall}, 32'd1);
    advance();
    settle();
    check_val("lw_alu_stall3", {31'd0, hz_if.stall}, 32'd0);
    check_val("lw_alu_fwd_rs", {30'd0, hz_if.fwd_rs_d}, 32'd3);
    advance();
    check_val("lw_alu_brcnt", hz_if.br_stall_cnt, cnt_exp(3));
    drain();

    // Same dest in E (tnew 1) and M (ready): E wins and stalls
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0);
    advance();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
    advance();
    drive_d(1'b1, 5'd7, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check_val("samedst_stall", {31'd0, hz_if.stall}, 32'd1);
    check_val("samedst_fwd_rs", {30'd0, hz_if.fwd_rs_d}, 32'd0);
    advance();
    settle();
    check_val("samedst_stall2", {31'd0, hz_if.stall}, 32'd0);
    check_val("samedst_fwd_rs2", {30'd0, hz_if.fwd_rs_d}, 32'd2);
    advance();
    check_val("samedst_brcnt", hz_if.br_stall_cnt, cnt_exp(4));
    drain();

    // Reset mid-stall clears slots immediately
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    advance();
    drive_d(1'b1, 5'd8, 2'd0, 5'd8, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle();
    check_val("midrst_pre_stall", {31'd0, hz_if.stall}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("midrst_stall", {31'd0, hz_if.stall}, 32'd0);
    check_val("midrst_fwd", {28'd0, hz_if.fwd_rs_d, hz_if.fwd_rt_d}, 32'd0);
    check_val("midrst_brcnt", hz_if.br_stall_cnt, 32'd0);
    #1;
    reset_n = 1'b1;
    advance();
    settle();
    check_val("postrst_stall", {31'd0, hz_if.stall}, 32'd0);
    check_val("postrst_fwd", {28'd0, hz_if.fwd_rs_d, hz_if.fwd_rt_d}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
